// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the M-extension divide unit.
// Optional result cache is enabled with DIV_RESULT_CACHE_EN.
package div_sequencer_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        OP_DIV  = 3'b100,
        OP_DIVU = 3'b101,
        OP_REM  = 3'b110,
        OP_REMU = 3'b111
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    // All four divide encodings share funct3[2] = 1.
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/div_datapath.sv
// Radix-2 restoring divide datapath: one quotient bit per step.
// Holds the partial remainder, the dividend/quotient shifter and the divisor.
module div_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dsr;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // Shift in the next dividend bit and try to subtract the divisor.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        diff     = shifted - {1'b0, dsr};
        fits     = ~diff[XLEN];
        rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], fits};
    end

    // Load operands on accept, advance one bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dsr <= divisor;
        end else if (step) begin
            quo <= quo_next;
            rem <= rem_next;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Divide sequencer: FSM, counter, sign fix-up, special cases.
// Define DIV_RESULT_CACHE_EN to reuse the last completed result.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state;
    logic [CW-1:0]   cnt;
    logic            rem_sel;
    logic            neg_q;
    logic            neg_r;
    logic            accept;
    logic            sgn_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            special;
    logic [XLEN-1:0] sp_q;
    logic [XLEN-1:0] sp_r;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] fin_q;
    logic [XLEN-1:0] fin_r;
    logic            last;
    logic            hit;
    logic [XLEN-1:0] hit_res;

    assign stall_o = start_i & is_div_op(funct3_i) & ~flush_i
                   & (state != S_DONE);

    // Operand decode, magnitudes, special cases and final sign fix-up.
    always_comb begin
        accept  = (state == S_IDLE) & start_i & is_div_op(funct3_i)
                & ~flush_i;
        sgn_in  = ~funct3_i[0];
        a_neg   = sgn_in & dividend_i[XLEN-1];
        b_neg   = sgn_in & divisor_i[XLEN-1];
        a_mag   = a_neg ? -dividend_i : dividend_i;
        b_mag   = b_neg ? -divisor_i : divisor_i;
        special = 1'b0;
        sp_q    = dividend_i;
        sp_r    = '0;
        if (divisor_i == '0) begin
            special = 1'b1;
            sp_q    = '1;
            sp_r    = dividend_i;
        end else if (sgn_in && dividend_i == MIN_NEG
                     && divisor_i == '1) begin
            special = 1'b1;
        end
        fin_q = neg_q ? -quo_next : quo_next;
        fin_r = neg_r ? -rem_next : rem_next;
        last  = (state == S_CALC) & (cnt == '0) & ~flush_i;
    end

    div_datapath #(.XLEN(XLEN)) u_dp (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (accept),
        .step     ((state == S_CALC) & ~flush_i),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic            c_valid;
    logic [XLEN-1:0] c_a;
    logic [XLEN-1:0] c_b;
    logic            c_sgn;
    logic [XLEN-1:0] c_q;
    logic [XLEN-1:0] c_r;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            op_sgn;

    always_comb begin
        hit     = c_valid & (c_a == dividend_i) & (c_b == divisor_i)
                & (c_sgn == sgn_in);
        hit_res = funct3_i[1] ? c_r : c_q;
    end

    // Track in-flight operands and record every completed result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_valid <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_sgn   <= 1'b0;
            c_q     <= '0;
            c_r     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_sgn  <= 1'b0;
        end else if (accept) begin
            op_a   <= dividend_i;
            op_b   <= divisor_i;
            op_sgn <= sgn_in;
            if (special && !hit) begin
                c_valid <= 1'b1;
                c_a     <= dividend_i;
                c_b     <= divisor_i;
                c_sgn   <= sgn_in;
                c_q     <= sp_q;
                c_r     <= sp_r;
            end
        end else if (last) begin
            c_valid <= 1'b1;
            c_a     <= op_a;
            c_b     <= op_b;
            c_sgn   <= op_sgn;
            c_q     <= fin_q;
            c_r     <= fin_r;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    // Sequencer FSM with registered busy/done/result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            rem_sel  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            rem_sel <= funct3_i[1];
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            if (hit) begin
                                result_o <= hit_res;
                                done_o   <= 1'b1;
                                state    <= S_DONE;
                            end else if (special) begin
                                result_o <= funct3_i[1] ? sp_r : sp_q;
                                done_o   <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                cnt    <= CW'(XLEN - 1);
                                busy_o <= 1'b1;
                                state  <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            result_o <= rem_sel ? fin_r : fin_q;
                            done_o   <= 1'b1;
                            busy_o   <= 1'b0;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed plan plus random ops
// against an arithmetic reference model (cache-aware via DIV_RESULT_CACHE_EN).
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    // Reference cache state: last completed operands.
    bit          cv = 1'b0;
    logic [31:0] ca;
    logic [31:0] cb;
    bit          cs;
    logic [31:0] last_x = 32'd100;
    logic [31:0] last_y = 32'd7;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .funct3_i   (funct3),
        .dividend_i (a),
        .divisor_i  (b),
        .flush_i    (flush),
        .stall_o    (stall),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [2:0] f,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        bit is_rem;
        sx = x;
        sy = y;
        is_rem = f[1];
        if (y == 0) return is_rem ? x : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (x == MIN_NEG && y == 32'hFFFF_FFFF)
                return is_rem ? 32'd0 : x;
            return is_rem ? 32'(sx % sy) : 32'(sx / sy);
        end
        return is_rem ? x % y : x / y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] x, input logic [31:0] y);
        bit fast;
        int lat;
        int cyc;
        int hs_bad;
        fast = (y == 0) || (!f[0] && x == MIN_NEG && y == 32'hFFFF_FFFF);
        fast = fast || (CACHE && cv && ca == x && cb == y && cs == !f[0]);
        lat = fast ? 1 : XLEN + 1;
        @(negedge clk);
        start = 1'b1;
        funct3 = f;
        a = x;
        b = y;
        cyc = 0;
        hs_bad = 0;
        while (1) begin
            #1;
            if (done) begin
                if (stall !== 1'b0 || busy !== 1'b0) hs_bad++;
                break;
            end
            if (stall !== (cyc < lat)) hs_bad++;
            if (busy !== (!fast && cyc >= 1 && cyc < lat)) hs_bad++;
            if (cyc >= 100) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " result"}, result, ref_div(f, x, y));
        check({tag, " stall/busy errs"}, 32'(hs_bad), 32'd0);
        cv = 1'b1;
        ca = x;
        cb = y;
        cs = !f[0];
        last_x = x;
        last_y = y;
    endtask

    initial begin
        logic [31:0] held;
        logic [2:0]  rf;
        logic [31:0] rx;
        logic [31:0] ry;
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        funct3 = 3'b000;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", 32'(stall), 32'd0);

        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7);
        run_op("remu 100/7", OP_REMU, 32'd100, 32'd7);
        run_op("div -7/2", OP_DIV, -32'sd7, 32'd2);
        run_op("rem -7/2", OP_REM, -32'sd7, 32'd2);
        run_op("rem 7/-2", OP_REM, 32'd7, -32'sd2);
        run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0);
        run_op("remu 5/0", OP_REMU, 32'd5, 32'd0);
        run_op("div ovf", OP_DIV, MIN_NEG, 32'hFFFF_FFFF);
        run_op("rem ovf", OP_REM, MIN_NEG, 32'hFFFF_FFFF);
        run_op("div 100/7", OP_DIV, 32'd100, 32'd7);
        run_op("rem 100/7", OP_REM, 32'd100, 32'd7);
        run_op("divu 100/7 again", OP_DIVU, 32'd100, 32'd7);

        // Flush mid-CALC: no done, result held, restart completes.
        held = result;
        @(negedge clk);
        start = 1'b1;
        funct3 = OP_DIVU;
        a = 32'd9;
        b = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result held", result, held);
        run_op("divu 9/3 reissue", OP_DIVU, 32'd9, 32'd3);

        for (int i = 0; i < 30; i++) begin
            rf = 3'(4 + $urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin
                    rx = MIN_NEG;
                    ry = 32'hFFFF_FFFF;
                end
                2: begin
                    rx = last_x;
                    ry = last_y;
                end
                3: begin
                    rx = 32'($urandom_range(0, 1000)) - 32'd500;
                    ry = 32'($urandom_range(1, 20));
                end
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rf, rx, ry);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
